// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, index/data types and index validity helper for regfile_scoreboard
package regfile_pkg;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 31;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
  localparam int ZERO_REG     = DEF_ZERO_REG;
  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;
  function automatic logic idx_ok(int idx, int num_regs, int zero_reg);
    return (idx < num_regs) && (idx != zero_reg);
  endfunction
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: writeback, read-port and issue signals of the register file scoreboard
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD
) ();
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic                     RegWrite;
  logic [ADDR_W-1:0]        WriteRegister;
  logic [DATA_W-1:0]        WriteData;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_reg;
  logic                     issue_ready;
  logic [ADDR_W:0]          busy_count;
  modport master (
    output RegWrite, WriteRegister, WriteData, rd_addr, issue_valid, issue_reg,
    input  rd_data, rd_busy, issue_ready, busy_count
  );
  modport slave (
    input  RegWrite, WriteRegister, WriteData, rd_addr, issue_valid, issue_reg,
    output rd_data, rd_busy, issue_ready, busy_count
  );
endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with zero/range masking; REGFILE_BYPASS_EN adds write forwarding
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] i_busy,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0]   i_wr_data,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_busy
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic w_ok;
  logic w_byp;
  // select the addressed register, forcing 0/not-busy for the zero register and out-of-range indices
  always_comb begin
    w_ok   = idx_ok(32'(i_addr), NUM_REGS, ZERO_REG);
    w_byp  = BYPASS && i_wr_en && (i_wr_addr == i_addr);
    o_data = !w_ok ? '0 : w_byp ? i_wr_data : i_regs[i_addr];
    o_busy = w_ok && !w_byp && i_busy[i_addr];
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read-port register file with per-register busy scoreboard (option: REGFILE_BYPASS_EN)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input logic clk,
  input logic rst_n,
  regfile_scoreboard_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int CNT_W  = ADDR_W + 1;
  logic [DATA_W-1:0]        r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]      r_busy;
  logic [CNT_W-1:0]         r_busy_count;
  logic                     w_wr_ok;
  logic                     w_iss_ok;
  logic                     w_ready;
  logic                     w_set;
  logic                     w_clr;
  logic [NUM_REGS-1:0]      w_set_mask;
  logic [NUM_REGS-1:0]      w_clr_mask;
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [NUM_RD-1:0]        w_rd_busy;
  // qualify writeback and issue; ready looks only at the registered busy bit, never at the write port
  always_comb begin
    w_wr_ok    = bus.RegWrite && idx_ok(32'(bus.WriteRegister), NUM_REGS, ZERO_REG);
    w_iss_ok   = idx_ok(32'(bus.issue_reg), NUM_REGS, ZERO_REG);
    w_ready    = !w_iss_ok || !r_busy[bus.issue_reg];
    w_set      = bus.issue_valid && w_ready && w_iss_ok;
    w_clr      = w_wr_ok && r_busy[bus.WriteRegister];
    w_set_mask = w_set ? NUM_REGS'(1) << bus.issue_reg : '0;
    w_clr_mask = w_wr_ok ? NUM_REGS'(1) << bus.WriteRegister : '0;
  end
  // architectural storage; dropped writes never reach here because w_wr_ok masks them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_regs <= '{default: '0};
    else if (w_wr_ok) r_regs[bus.WriteRegister] <= bus.WriteData;
  end
  // busy vector with set-over-clear priority and a running count kept equal to its popcount
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= (r_busy & ~w_clr_mask) | w_set_mask;
      r_busy_count <= r_busy_count + CNT_W'(w_set) - CNT_W'(w_clr);
    end
  end
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_read_port #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .i_addr   (bus.rd_addr[p*ADDR_W +: ADDR_W]),
      .i_regs   (r_regs),
      .i_busy   (r_busy),
      .i_wr_en  (w_wr_ok),
      .i_wr_addr(bus.WriteRegister),
      .i_wr_data(bus.WriteData),
      .o_data   (w_rd_data[p*DATA_W +: DATA_W]),
      .o_busy   (w_rd_busy[p])
    );
  end
  assign bus.rd_data     = w_rd_data;
  assign bus.rd_busy     = w_rd_busy;
  assign bus.issue_ready = w_ready;
  assign bus.busy_count  = r_busy_count;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: table vectors, directed reset sequence and random traffic against a reference model
module tb_regfile_scoreboard;
  import regfile_pkg::*;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [63:0] DV  = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] R10 = BYP ? 64'd42 : 64'd0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(2)) bus ();
  regfile_scoreboard #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(31)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        iv;
    logic [4:0]  ir;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        b0;
    logic        b1;
    logic        rdy;
    logic [5:0]  cnt;
  } vec_t;
  vec_t tbl [15];

  int n_tests = 0;
  int n_fail = 0;
  logic [63:0] m_regs [32];
  bit          m_busy [32];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic we, logic [4:0] wa, logic [63:0] wd, logic [4:0] ra0, logic [4:0] ra1,
                       logic iv, logic [4:0] ir);
    bus.RegWrite      = we;
    bus.WriteRegister = wa;
    bus.WriteData     = wd;
    bus.rd_addr       = {ra1, ra0};
    bus.issue_valid   = iv;
    bus.issue_reg     = ir;
  endtask

  function automatic bit byp_hit(logic [4:0] a);
    return BYP && bus.RegWrite && (bus.WriteRegister == a) && (a != 5'd31);
  endfunction

  function automatic logic [63:0] m_data(logic [4:0] a);
    return (a == 5'd31) ? 64'd0 : byp_hit(a) ? bus.WriteData : m_regs[a];
  endfunction

  function automatic logic m_bsy(logic [4:0] a);
    return (a != 5'd31) && !byp_hit(a) && m_busy[a];
  endfunction

  function automatic logic m_ready();
    return (bus.issue_reg == 5'd31) || !m_busy[bus.issue_reg];
  endfunction

  function automatic logic [63:0] m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return 64'(c);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, " rd_data0"}, bus.rd_data[63:0], m_data(bus.rd_addr[4:0]));
    chk({tag, " rd_data1"}, bus.rd_data[127:64], m_data(bus.rd_addr[9:5]));
    chk({tag, " rd_busy0"}, 64'(bus.rd_busy[0]), 64'(m_bsy(bus.rd_addr[4:0])));
    chk({tag, " rd_busy1"}, 64'(bus.rd_busy[1]), 64'(m_bsy(bus.rd_addr[9:5])));
    chk({tag, " issue_ready"}, 64'(bus.issue_ready), 64'(m_ready()));
    chk({tag, " busy_count"}, 64'(bus.busy_count), m_count());
  endtask

  task automatic tick();
    logic        we  = bus.RegWrite;
    logic [4:0]  wa  = bus.WriteRegister;
    logic [63:0] wd  = bus.WriteData;
    logic        acc = bus.issue_valid && m_ready();
    logic [4:0]  ir  = bus.issue_reg;
    @(posedge clk);
    if (we && wa != 5'd31) begin
      m_regs[wa] = wd;
      m_busy[wa] = 1'b0;
    end
    if (acc && ir != 5'd31) m_busy[ir] = 1'b1;
    #1;
  endtask

  function automatic logic [4:0] rnd_idx();
    return ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    tbl[0]  = '{1'b0, 5'd0,  64'd0, 5'd0,  5'd31, 1'b0, 5'd0,  64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 6'd0};
    tbl[1]  = '{1'b1, 5'd5,  DV,    5'd0,  5'd1,  1'b0, 5'd0,  64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 6'd0};
    tbl[2]  = '{1'b1, 5'd31, '1,    5'd5,  5'd5,  1'b0, 5'd0,  DV,    DV,    1'b0, 1'b0, 1'b1, 6'd0};
    tbl[3]  = '{1'b0, 5'd0,  64'd0, 5'd31, 5'd7,  1'b1, 5'd7,  64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 6'd0};
    tbl[4]  = '{1'b0, 5'd0,  64'd0, 5'd7,  5'd31, 1'b1, 5'd7,  64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 6'd1};
    tbl[5]  = '{1'b1, 5'd7,  64'd9, 5'd5,  5'd1,  1'b0, 5'd0,  DV,    64'd0, 1'b0, 1'b0, 1'b1, 6'd1};
    tbl[6]  = '{1'b0, 5'd0,  64'd0, 5'd7,  5'd31, 1'b1, 5'd3,  64'd9, 64'd0, 1'b0, 1'b0, 1'b1, 6'd0};
    tbl[7]  = '{1'b1, 5'd3,  64'd1, 5'd4,  5'd7,  1'b1, 5'd4,  64'd0, 64'd9, 1'b0, 1'b0, 1'b1, 6'd1};
    tbl[8]  = '{1'b0, 5'd0,  64'd0, 5'd3,  5'd4,  1'b0, 5'd0,  64'd1, 64'd0, 1'b0, 1'b1, 1'b1, 6'd1};
    tbl[9]  = '{1'b1, 5'd10, 64'd42, 5'd10, 5'd10, 1'b0, 5'd0, R10,   R10,   1'b0, 1'b0, 1'b1, 6'd1};
    tbl[10] = '{1'b0, 5'd0,  64'd0, 5'd10, 5'd31, 1'b0, 5'd0,  64'd42, 64'd0, 1'b0, 1'b0, 1'b1, 6'd1};
    tbl[11] = '{1'b0, 5'd0,  64'd0, 5'd31, 5'd31, 1'b1, 5'd31, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 6'd1};
    tbl[12] = '{1'b0, 5'd0,  64'd0, 5'd31, 5'd4,  1'b0, 5'd0,  64'd0, 64'd0, 1'b0, 1'b1, 1'b1, 6'd1};
    tbl[13] = '{1'b1, 5'd12, 64'd5, 5'd0,  5'd0,  1'b1, 5'd12, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 6'd1};
    tbl[14] = '{1'b0, 5'd0,  64'd0, 5'd12, 5'd4,  1'b0, 5'd0,  64'd5, 64'd0, 1'b1, 1'b1, 1'b1, 6'd2};

    m_reset();
    drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 64'd0, 5'(a), 5'(a), 1'b0, 5'd0);
      #1;
      chk($sformatf("reset rd_data0[%0d]", a), bus.rd_data[63:0], 64'd0);
      chk($sformatf("reset rd_data1[%0d]", a), bus.rd_data[127:64], 64'd0);
      chk($sformatf("reset rd_busy[%0d]", a), 64'(bus.rd_busy), 64'd0);
    end
    chk("reset busy_count", 64'(bus.busy_count), 64'd0);
    chk("reset issue_ready", 64'(bus.issue_ready), 64'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra0, tbl[i].ra1, tbl[i].iv, tbl[i].ir);
      #2;
      chk($sformatf("tbl[%0d] rd_data0", i), bus.rd_data[63:0], tbl[i].d0);
      chk($sformatf("tbl[%0d] rd_data1", i), bus.rd_data[127:64], tbl[i].d1);
      chk($sformatf("tbl[%0d] rd_busy0", i), 64'(bus.rd_busy[0]), 64'(tbl[i].b0));
      chk($sformatf("tbl[%0d] rd_busy1", i), 64'(bus.rd_busy[1]), 64'(tbl[i].b1));
      chk($sformatf("tbl[%0d] issue_ready", i), 64'(bus.issue_ready), 64'(tbl[i].rdy));
      chk($sformatf("tbl[%0d] busy_count", i), 64'(bus.busy_count), 64'(tbl[i].cnt));
      tick();
    end

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), rnd_idx(), {$urandom, $urandom}, rnd_idx(), rnd_idx(),
            1'($urandom_range(0, 1)), rnd_idx());
      #2;
      check_model($sformatf("rnd[%0d]", i));
      tick();
    end

    drive(1'b1, 5'd1, 64'h11, 5'd1, 5'd2, 1'b0, 5'd0);
    tick();
    drive(1'b1, 5'd2, 64'h22, 5'd1, 5'd2, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 64'd0, 5'd1, 5'd2, 1'b1, 5'd1);
    tick();
    drive(1'b0, 5'd0, 64'd0, 5'd1, 5'd2, 1'b1, 5'd2);
    tick();
    drive(1'b1, 5'd2, 64'd77, 5'd1, 5'd2, 1'b1, 5'd1);
    #2;
    check_model("pre-reset");
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("async reset busy_count", 64'(bus.busy_count), 64'd0);
    chk("async reset rd_busy", 64'(bus.rd_busy), 64'd0);
    chk("async reset issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("async reset R1", bus.rd_data[63:0], 64'd0);
    chk("async reset R2", bus.rd_data[127:64], 64'd0);
    drive(1'b0, 5'd0, 64'd0, 5'd1, 5'd2, 1'b0, 5'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post-reset R2", bus.rd_data[127:64], 64'd0);
    chk("post-reset busy_count", 64'(bus.busy_count), 64'd0);
    drive(1'b0, 5'd0, 64'd0, 5'd9, 5'd2, 1'b1, 5'd9);
    tick();
    chk("post-reset issue R9 count", 64'(bus.busy_count), 64'd1);
    chk("post-reset issue R9 busy", 64'(bus.rd_busy[0]), 64'd1);
    check_model("post-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
